avalon_mem_responder: RTL and testbench
=======================================

# avalon_mem_responder

- Memory-side responder for the CPU's Avalon-style data/instruction bus.
- Accepts word reads and byte-enabled writes issued by the CPU control path (fetch, `lw`, `sw`).
- Inserts a programmable number of wait states and holds a word-organised RAM.
- Used as the memory model behind the CPU in testbenches and as the on-chip RAM in synthesis.

## Interface
Parameters:
- `MEM_WORDS`, 1024: RAM depth in 32-bit words.
- `BASE_ADDR`, 32'hBFC0_0000: byte address of word 0.
- `WAIT_STATES`, 1: cycles `waitrequest` stays high per transaction. Legal range is 1 to 15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `address`  in  32  byte address from the CPU.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  store data.
- `byteenable`  in  4  write lane enables; bit i selects bits [8i+7:8i].
- `waitrequest`  out  1  high = request not yet accepted.
- `readdata`  out  32  read result, valid in the accept cycle.
- `bus_error`  out  1  sticky error flag.

## Operation
- States are IDLE, WAIT and ACK. A 4-bit wait counter runs in WAIT.
- `waitrequest` is combinational: `(read|write) && state!=ACK`. It is 0 in ACK.
- IDLE:
  - On a clock edge with `read|write`, latch `address`, `writedata`, `byteenable` and the operation; set counter to 1.
  - If `WAIT_STATES==1`, go to ACK; otherwise go to WAIT.
- WAIT:
  - Counter increments each edge. When it reaches `WAIT_STATES`, go to ACK.
  - Live address/data changes are ignored; the latched values are used.
- ACK:
  - `waitrequest=0`.
  - Read: `readdata` holds the latched word. It is registered on the edge entering ACK.
  - Write: enabled lanes of the word are updated on the edge leaving ACK; disabled lanes keep their value.
  - Always returns to IDLE. One idle cycle separates back-to-back transactions.
- Address decode: index = `(address-BASE_ADDR)>>2`.
  - Invalid address: `address[1:0]!=0`, or index ≥ `MEM_WORDS`, or `address<BASE_ADDR`.
  - Invalid address on read: `readdata=0`, `bus_error` set.
  - Invalid address on write: memory unchanged, `bus_error` set. The handshake still completes normally.
- `read&&write` together is illegal:
  - Treated as a read with no memory update.
  - `bus_error` set.
- Request dropped (`read|write` low) in WAIT or ACK:
  - Abort to IDLE on the next edge. No memory update; `bus_error` set.
- `byteenable==0` write: legal, no update, no error.
- Reads ignore `byteenable` and return the full word.
- `bus_error` stays set until reset.

## Timing
- Reset (asynchronous, while `reset_n=0`):
  - State IDLE, counter 0, `readdata=0`, `bus_error=0`.
  - `waitrequest` follows its equation: 0 with no request, 1 with a request.
  - RAM contents are not cleared. The array is zero-initialised at simulation start.
- Request first seen in cycle 0:
  - `waitrequest=1` for cycles 0..`WAIT_STATES-1`.
  - Accept cycle is cycle `WAIT_STATES` (ACK), with `readdata` valid and write commit at its closing edge.
- Throughput: one transaction per `WAIT_STATES+1` cycles.
- Reset asserted mid-transaction: the transaction is abandoned and no write is committed. A write whose ACK-closing edge coincides with `reset_n` low is not committed.
- Read after write to the same word: the read's ACK returns the new data, since the write commits before the next request is latched.

## Test plan
- Reset with `read=write=0` → `waitrequest=0`, `readdata=0`, `bus_error=0`. Assert `read` → `waitrequest=1` immediately.
- `WAIT_STATES=2`: write 32'hDEADBEEF, be=4'hF to 32'hBFC0_0010, then read the same address → `waitrequest` high exactly 2 cycles per transaction; `readdata=32'hDEADBEEF` in ACK.
- Partial write: write 32'h11223344 be=4'hF, then 32'hAABBCCDD be=4'b0101 to 32'hBFC0_0004; read → 32'h11BB33DD.
- Invalid addresses:
  - Read 32'hBFC0_0002 → `readdata=0`, `bus_error=1`.
  - After reset, write to `BASE_ADDR+4*MEM_WORDS` → completes in `WAIT_STATES+1` cycles, `bus_error=1`, word 0 unchanged.
- Protocol faults:
  - `read` and `write` high together with be=4'hF → no memory change, `bus_error=1`.
  - After reset, drop `write` during WAIT (`WAIT_STATES=3`) → FSM in IDLE next cycle, target word unchanged, `bus_error=1`.
- Pulse `reset_n` low during WAIT of a write → `readdata=0`, `bus_error=0`, target word unchanged. A subsequent read completes with normal latency.

Source files
------------

// File: rtl/avalon_mem_if.sv
// Avalon-style memory bus between the CPU control path and the memory responder.
//   address/read/write/writedata/byteenable : request from the master
//   waitrequest/readdata/bus_error          : response from the slave
interface avalon_mem_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, bus_error
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// Word-organised RAM behind an Avalon-style bus with programmable wait states.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (RAM contents are kept)
//   bus     : slave side of avalon_mem_if (waitrequest is combinational,
//             readdata/bus_error are registered, bus_error is sticky)
module avalon_mem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    avalon_mem_if.slave  bus
);

    localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        op_rd_q;    // read, including the illegal read+write case
    logic        op_wr_q;    // pure write
    logic        op_both_q;  // read and write asserted together
    logic [31:0] readdata_q;
    logic        bus_error_q;

    logic [31:0] mem [MEM_WORDS];

    logic             req;
    logic             latch_en;
    logic             enter_ack;
    logic             abort;
    logic             commit;
    logic [31:0]      dec_addr;
    logic             dec_rd;
    logic             dec_both;
    logic [31:0]      byte_off;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] word_idx;
    logic             addr_ok;

    assign req             = bus.read | bus.write;
    assign bus.waitrequest = req && (state_q != S_ACK);
    assign bus.readdata    = readdata_q;
    assign bus.bus_error   = bus_error_q;

    // With one wait state ACK is entered straight from IDLE, so the decode
    // must look at the live request; otherwise it uses the latched one.
    always_comb begin
        dec_addr = addr_q;
        dec_rd   = op_rd_q;
        dec_both = op_both_q;
        if (state_q == S_IDLE) begin
            dec_addr = bus.address;
            dec_rd   = bus.read;
            dec_both = bus.read & bus.write;
        end
        byte_off = dec_addr - BASE_ADDR;
        word_off = byte_off >> 2;
        word_idx = word_off[IDX_W-1:0];
        addr_ok  = (dec_addr[1:0] == 2'b00) && (dec_addr >= BASE_ADDR) &&
                   (word_off < 32'(MEM_WORDS));
    end

    // Next-state and control strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        enter_ack = 1'b0;
        abort     = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'd1;
                    if (WAIT_STATES == 1) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = 4'(cnt_q + 4'd1);
                    if (cnt_d == WS_LAST) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                if (!req) begin
                    abort = 1'b1;
                end else begin
                    commit = op_wr_q && addr_ok;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, request capture, read result and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            op_rd_q     <= 1'b0;
            op_wr_q     <= 1'b0;
            op_both_q   <= 1'b0;
            readdata_q  <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                addr_q    <= bus.address;
                wdata_q   <= bus.writedata;
                be_q      <= bus.byteenable;
                op_rd_q   <= bus.read;
                op_wr_q   <= bus.write & ~bus.read;
                op_both_q <= bus.read & bus.write;
            end
            if (enter_ack) begin
                if (dec_rd) begin
                    readdata_q <= addr_ok ? mem[word_idx] : 32'd0;
                end
                if (!addr_ok || dec_both) begin
                    bus_error_q <= 1'b1;
                end
            end
            if (abort) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    // Write commit on the edge leaving ACK; a low reset_n blocks it.
    always_ff @(posedge clk) begin
        if (reset_n && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Randomised self-checking bench for avalon_mem_responder against a
// word-array reference model of the memory and the sticky error flag.
module tb_avalon_mem_responder;

    localparam int unsigned WS   = 3;
    localparam int unsigned MW   = 64;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    avalon_mem_if bus();

    avalon_mem_responder #(
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] model_mem [MW];
    bit          model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (((a - BASE) >> 2) < 32'(MW));
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One full transaction: request held until the accept cycle, then dropped.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rdata);
        int unsigned cyc;
        bit          ok;
        logic [31:0] exp_rd;
        ok = addr_ok(a);
        bus.address    = a;
        bus.writedata  = wd;
        bus.byteenable = be;
        bus.read       = rd;
        bus.write      = wr;
        cyc = 0;
        #1;
        while (bus.waitrequest === 1'b1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(WS));
        rdata  = bus.readdata;
        exp_rd = ok ? model_mem[word_of(a)] : 32'd0;
        if (rd) check("readdata", rdata, exp_rd);
        if (!ok || (rd && wr)) model_err = 1'b1;
        check("bus_error", 32'(bus.bus_error), 32'(model_err));
        if (wr && !rd && ok) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) model_mem[word_of(a)][8*i +: 8] = wd[8*i +: 8];
        end
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n   = 1'b0;
        model_err = 1'b0;
        #2;
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_bus_error", 32'(bus.bus_error), 32'd0);
        check("rst_waitreq", 32'(bus.waitrequest), 32'(bus.read | bus.write));
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic [31:0] a;
        logic [31:0] old_word;
        int unsigned r;

        bus.address    = 32'd0;
        bus.writedata  = 32'd0;
        bus.byteenable = 4'd0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;

        // Reset state and combinational waitrequest under reset.
        #12;
        check("reset_waitreq_idle", 32'(bus.waitrequest), 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_bus_error", 32'(bus.bus_error), 32'd0);
        bus.read = 1'b1;
        #1;
        check("reset_waitreq_req", 32'(bus.waitrequest), 32'd1);
        bus.read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < int'(MW); i++)
            txn(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rdata);

        // Full-word write then read back.
        txn(1'b0, 1'b1, 32'hBFC0_0010, 32'hDEADBEEF, 4'hF, rdata);
        txn(1'b1, 1'b0, 32'hBFC0_0010, 32'd0, 4'h0, rdata);
        check("deadbeef", rdata, 32'hDEADBEEF);

        // Partial lane write.
        txn(1'b0, 1'b1, 32'hBFC0_0004, 32'h11223344, 4'hF, rdata);
        txn(1'b0, 1'b1, 32'hBFC0_0004, 32'hAABBCCDD, 4'b0101, rdata);
        txn(1'b1, 1'b0, 32'hBFC0_0004, 32'd0, 4'h0, rdata);
        check("partial", rdata, 32'h11BB33DD);

        // Zero byteenable write: no change, no error.
        txn(1'b0, 1'b1, 32'hBFC0_0004, 32'h0, 4'h0, rdata);
        txn(1'b1, 1'b0, 32'hBFC0_0004, 32'd0, 4'h0, rdata);
        check("be_zero", rdata, 32'h11BB33DD);

        // Misaligned read.
        txn(1'b1, 1'b0, 32'hBFC0_0002, 32'd0, 4'h0, rdata);
        check("misaligned_rd", rdata, 32'd0);

        // Out-of-range write leaves word 0 alone.
        pulse_reset();
        old_word = model_mem[0];
        txn(1'b0, 1'b1, BASE + 32'(4 * MW), 32'hCAFEF00D, 4'hF, rdata);
        txn(1'b1, 1'b0, BASE, 32'd0, 4'h0, rdata);
        check("oob_word0", rdata, old_word);

        // read+write together: treated as read, no update.
        pulse_reset();
        old_word = model_mem[2];
        txn(1'b1, 1'b1, BASE + 32'd8, ~old_word, 4'hF, rdata);
        txn(1'b1, 1'b0, BASE + 32'd8, 32'd0, 4'h0, rdata);
        check("rw_both_word", rdata, old_word);

        // Write dropped during WAIT.
        pulse_reset();
        old_word = model_mem[8];
        bus.address = BASE + 32'h20; bus.writedata = ~old_word;
        bus.byteenable = 4'hF; bus.write = 1'b1;
        @(negedge clk);
        check("drop_waitreq", 32'(bus.waitrequest), 32'd1);
        bus.write = 1'b0;
        model_err = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b0, BASE + 32'h20, 32'd0, 4'h0, rdata);
        check("drop_word", rdata, old_word);

        // Reset pulse during WAIT of a write.
        old_word = model_mem[12];
        bus.address = BASE + 32'h30; bus.writedata = ~old_word;
        bus.byteenable = 4'hF; bus.write = 1'b1;
        @(negedge clk);
        pulse_reset();
        txn(1'b1, 1'b0, BASE + 32'h30, 32'd0, 4'h0, rdata);
        check("rst_wait_word", rdata, old_word);

        // Reset asserted in ACK of a write: closing edge must not commit.
        old_word = model_mem[13];
        bus.address = BASE + 32'h34; bus.writedata = ~old_word;
        bus.byteenable = 4'hF; bus.write = 1'b1;
        repeat (WS) @(negedge clk);
        #1;
        check("ack_waitreq", 32'(bus.waitrequest), 32'd0);
        pulse_reset();
        txn(1'b1, 1'b0, BASE + 32'h34, 32'd0, 4'h0, rdata);
        check("rst_ack_word", rdata, old_word);

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 99) < 10) pulse_reset();
            r = $urandom_range(0, 99);
            if (r < 85) a = BASE + 32'(4 * $urandom_range(0, MW - 1));
            else if (r < 90) a = BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 7));
            else if (r < 95) a = BASE - 32'(4 * $urandom_range(1, 4));
            else a = BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(1, 3));
            r = $urandom_range(0, 99);
            if (r < 45)      txn(1'b1, 1'b0, a, $urandom, 4'($urandom), rdata);
            else if (r < 93) txn(1'b0, 1'b1, a, $urandom, 4'($urandom), rdata);
            else             txn(1'b1, 1'b1, a, $urandom, 4'($urandom), rdata);
        end

        // Final sweep of the whole array against the model.
        pulse_reset();
        for (int i = 0; i < int'(MW); i++)
            txn(1'b1, 1'b0, BASE + 32'(4 * i), 32'd0, 4'h0, rdata);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
